// File: rtl/rvfi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rvfi_pkg
// Description : Shared types and constants for the RVFI commit serializer:
//               the retire packet struct, RV32I opcode and funct3 constants,
//               and the decode-trap classification function.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package rvfi_pkg;

   typedef struct packed {
      logic [31:0] inst;
      logic [4:0]  rs1_addr;
      logic [4:0]  rs2_addr;
      logic [31:0] rs1_rdata;
      logic [31:0] rs2_rdata;
      logic [4:0]  rd_addr;
      logic [31:0] rd_wdata;
      logic [31:0] pc_rdata;
      logic [31:0] pc_wdata;
      logic [31:0] mem_addr;
      logic [3:0]  mem_rmask;
      logic [3:0]  mem_wmask;
      logic [31:0] mem_rdata;
      logic [31:0] mem_wdata;
   } rvfi_pkt_t;

   // RV32I base opcodes
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   // LOAD funct3
   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   // STORE funct3
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   // BRANCH funct3 (010/011 are unassigned encodings)
   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   // Returns 1 when the instruction is not a recognised RV32I encoding.
   function automatic logic rvfi_trap(input logic [31:0] inst);
      logic [6:0] opc;
      logic [2:0] f3;
      logic       trap;
      opc  = inst[6:0];
      f3   = inst[14:12];
      trap = 1'b1;
      case (opc)
         OPC_LUI, OPC_AUIPC, OPC_OP_IMM, OPC_OP, OPC_JAL, OPC_JALR:
            trap = 1'b0;
         OPC_BRANCH:
            trap = !(f3 inside {F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU});
         OPC_LOAD:
            trap = !(f3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU});
         OPC_STORE:
            trap = !(f3 inside {F3_SB, F3_SH, F3_SW});
         default:
            trap = 1'b1;
      endcase
      return trap;
   endfunction

endpackage
`default_nettype wire

// File: rtl/rvfi_commit_fifo.sv
`default_nettype none
// ============================================================================
// Module      : rvfi_commit_fifo
// Description : Circular buffer with NCH compacting write ports and a single
//               read port. Valid write lanes land in consecutive slots in
//               ascending lane order. Exposes current occupancy.
// Ports       : clk        - clock
//               rst        - asynchronous active-low reset
//               wr_en_i    - global write enable for this cycle
//               wr_valid_i - per-lane write strobes
//               wr_pkt_i   - per-lane write data
//               rd_en_i    - pop head entry (caller guarantees count_o != 0)
//               rd_pkt_o   - head entry (combinational)
//               count_o    - occupancy, log2(DEPTH)+1 bits
// Revision    : 1.0 - initial release
// ============================================================================
module rvfi_commit_fifo
   import rvfi_pkg::*;
#(
   parameter int unsigned NCH   = 2,
   parameter int unsigned DEPTH = 8
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        wr_en_i,
   input  logic [NCH-1:0]              wr_valid_i,
   input  rvfi_pkt_t [NCH-1:0]         wr_pkt_i,
   input  logic                        rd_en_i,
   output rvfi_pkt_t                   rd_pkt_o,
   output logic [$clog2(DEPTH):0]      count_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0]   C_CNT_ONE = (AW+1)'(1);
   localparam logic [AW-1:0] C_PTR_ONE = AW'(1);

   rvfi_pkt_t        mem_q [DEPTH];
   logic [AW-1:0]    wptr_q, wptr_d;
   logic [AW-1:0]    rptr_q, rptr_d;
   logic [AW:0]      cnt_q,  cnt_d;
   logic [AW:0]      push_n;
   logic [AW-1:0]    slot [NCH];
   logic [NCH-1:0]   we;

   // Each lane's slot is the write pointer plus the number of enabled lanes
   // below it, which compacts holes left by invalid or dropped lanes.
   always_comb begin
      push_n = '0;
      for (int i = 0; i < NCH; i++) begin
         we[i]   = wr_en_i & wr_valid_i[i];
         slot[i] = wptr_q + push_n[AW-1:0];
         if (we[i]) begin
            push_n = push_n + C_CNT_ONE;
         end
      end
      wptr_d = wptr_q + push_n[AW-1:0];
      rptr_d = rd_en_i ? (rptr_q + C_PTR_ONE) : rptr_q;
      cnt_d  = cnt_q + push_n - (rd_en_i ? C_CNT_ONE : '0);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cnt_q  <= cnt_d;
      end
   end

   // Storage carries no reset; validity is tracked solely by the counter.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NCH; i++) begin
         if (we[i]) begin
            mem_q[slot[i]] <= wr_pkt_i[i];
         end
      end
   end

   assign rd_pkt_o = mem_q[rptr_q];
   assign count_o  = cnt_q;

endmodule
`default_nettype wire

// File: rtl/rvfi_commit_serializer.sv
`default_nettype none
// ============================================================================
// Module      : rvfi_commit_serializer
// Description : Serializes up to NCH RVFI retire packets per cycle into a
//               single in-order commit stream with program-order index,
//               decode-trap flag, sticky infinite-loop (halt) detection and
//               sticky overflow protocol-error flag. Bubbles (pc_rdata==0)
//               are dropped on entry.
// Ports       : clk        - clock
//               rst        - asynchronous active-low reset
//               in_valid   - per-channel retire strobe, channel 0 oldest
//               in_pkt     - per-channel retire packets
//               in_ready   - at least NCH free entries
//               out_commit - one-cycle pulse per committed instruction
//               out_pkt    - committed packet
//               out_order  - program-order index of out_pkt
//               out_trap   - decode-trap flag of out_pkt
//               out_halt   - sticky infinite-loop detect
//               overflow   - sticky protocol error (push while not ready)
// Revision    : 1.0 - initial release
// ============================================================================
module rvfi_commit_serializer
   import rvfi_pkg::*;
#(
   parameter int unsigned NCH      = 2,   // 1..4
   parameter int unsigned DEPTH    = 8,   // power of 2, >= 2*NCH
   parameter int unsigned HALT_CNT = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NCH-1:0]       in_valid,
   input  rvfi_pkt_t [NCH-1:0]  in_pkt,
   output logic                 in_ready,
   output logic                 out_commit,
   output rvfi_pkt_t            out_pkt,
   output logic [63:0]          out_order,
   output logic                 out_trap,
   output logic                 out_halt,
   output logic                 overflow
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned HW = $clog2(HALT_CNT + 1);
   localparam logic [AW:0]   C_READY_LIM = (AW+1)'(DEPTH - NCH);
   localparam logic [HW-1:0] C_HALT      = HW'(HALT_CNT);
   localparam logic [HW-1:0] C_HALT_ONE  = HW'(1);

   logic [NCH-1:0] w_keep;
   logic           w_viol;
   logic           w_wr_en;
   logic           w_pop;
   rvfi_pkt_t      w_rd_pkt;
   logic [AW:0]    w_count;

   logic           commit_q,   commit_d;
   rvfi_pkt_t      pkt_q,      pkt_d;
   logic [63:0]    out_order_q, out_order_d;
   logic [63:0]    order_q,    order_d;
   logic           trap_q,     trap_d;
   logic [HW-1:0]  halt_cnt_q, halt_cnt_d;
   logic           halt_q,     halt_d;
   logic           ovf_q,      ovf_d;

   // Ready depends only on registered occupancy, so it reads 1 in reset.
   assign in_ready = (w_count <= C_READY_LIM);
   assign w_viol   = (|in_valid) & ~in_ready;
   // The reset term keeps storage untouched while reset is held.
   assign w_wr_en  = in_ready & rst;
   assign w_pop    = (w_count != '0);

   always_comb begin
      for (int i = 0; i < NCH; i++) begin
         w_keep[i] = in_valid[i] && (in_pkt[i].pc_rdata != 32'd0);
      end
   end

   rvfi_commit_fifo #(
      .NCH   (NCH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .wr_en_i    (w_wr_en),
      .wr_valid_i (w_keep),
      .wr_pkt_i   (in_pkt),
      .rd_en_i    (w_pop),
      .rd_pkt_o   (w_rd_pkt),
      .count_o    (w_count)
   );

   // The halt counter is updated at pop time from the packet being
   // registered, so it reaches HALT_CNT in the same cycle that the
   // triggering commit is visible and out_halt follows one cycle later.
   always_comb begin
      commit_d    = w_pop;
      pkt_d       = pkt_q;
      trap_d      = trap_q;
      out_order_d = out_order_q;
      order_d     = order_q;
      halt_cnt_d  = halt_cnt_q;
      halt_d      = halt_q | (halt_cnt_q == C_HALT);
      ovf_d       = ovf_q | w_viol;
      if (w_pop) begin
         pkt_d       = w_rd_pkt;
         trap_d      = rvfi_trap(w_rd_pkt.inst);
         out_order_d = order_q;
         order_d     = order_q + 64'd1;
         if (w_rd_pkt.pc_rdata == w_rd_pkt.pc_wdata) begin
            if (halt_cnt_q != C_HALT) begin
               halt_cnt_d = halt_cnt_q + C_HALT_ONE;
            end
         end else begin
            halt_cnt_d = '0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         commit_q    <= 1'b0;
         pkt_q       <= '0;
         trap_q      <= 1'b0;
         out_order_q <= '0;
         order_q     <= '0;
         halt_cnt_q  <= '0;
         halt_q      <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         commit_q    <= commit_d;
         pkt_q       <= pkt_d;
         trap_q      <= trap_d;
         out_order_q <= out_order_d;
         order_q     <= order_d;
         halt_cnt_q  <= halt_cnt_d;
         halt_q      <= halt_d;
         ovf_q       <= ovf_d;
      end
   end

   assign out_commit = commit_q;
   assign out_pkt    = pkt_q;
   assign out_order  = out_order_q;
   assign out_trap   = trap_q;
   assign out_halt   = halt_q;
   assign overflow   = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_rvfi_commit_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_rvfi_commit_serializer
// Description : Self-checking bench for rvfi_commit_serializer (NCH=2,
//               DEPTH=8, HALT_CNT=2). Expected commits are queued at drive
//               time and compared as the DUT commits them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rvfi_commit_serializer;
   import rvfi_pkg::*;

   localparam int unsigned NCH      = 2;
   localparam int unsigned DEPTH    = 8;
   localparam int unsigned HALT_CNT = 2;

   logic                clk = 1'b0;
   logic                rst;
   logic [NCH-1:0]      in_valid;
   rvfi_pkt_t [NCH-1:0] in_pkt;
   logic                in_ready;
   logic                out_commit;
   rvfi_pkt_t           out_pkt;
   logic [63:0]         out_order;
   logic                out_trap;
   logic                out_halt;
   logic                overflow;

   rvfi_commit_serializer #(
      .NCH      (NCH),
      .DEPTH    (DEPTH),
      .HALT_CNT (HALT_CNT)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_pkt     (in_pkt),
      .in_ready   (in_ready),
      .out_commit (out_commit),
      .out_pkt    (out_pkt),
      .out_order  (out_order),
      .out_trap   (out_trap),
      .out_halt   (out_halt),
      .overflow   (overflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pcr;
      logic [31:0] pcw;
      logic [31:0] inst;
      logic [63:0] ord;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   int          n_tests   = 0;
   int          n_fail    = 0;
   int          n_commits = 0;
   logic [63:0] exp_order = '0;

   task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Independent table of legal RV32I encodings.
   function automatic logic model_trap(input logic [31:0] inst);
      logic [6:0] opc;
      logic [2:0] f3;
      opc = inst[6:0];
      f3  = inst[14:12];
      if (opc == 7'h37 || opc == 7'h17 || opc == 7'h13 || opc == 7'h33 ||
          opc == 7'h6F || opc == 7'h67)
         return 1'b0;
      if (opc == 7'h63) return (f3 == 3'd2) || (f3 == 3'd3);
      if (opc == 7'h03) return (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
      if (opc == 7'h23) return (f3 > 3'd2);
      return 1'b1;
   endfunction

   function automatic rvfi_pkt_t mk(input logic [31:0] pcr, input logic [31:0] pcw,
                                    input logic [31:0] inst);
      rvfi_pkt_t p;
      p          = '0;
      p.inst     = inst;
      p.pc_rdata = pcr;
      p.pc_wdata = pcw;
      p.rd_addr  = pcr[6:2];
      p.rd_wdata = pcr ^ 32'hA5A5_A5A5;
      p.mem_addr = pcr + 32'h1000;
      return p;
   endfunction

   // Drives one cycle of stimulus; queues expectations for packets the DUT
   // must accept, then advances to #1 after the edge.
   task automatic drive(input logic [1:0] v, input rvfi_pkt_t p0, input rvfi_pkt_t p1);
      rvfi_pkt_t p [2];
      exp_t      e;
      p[0] = p0;
      p[1] = p1;
      in_valid  = v;
      in_pkt[0] = p0;
      in_pkt[1] = p1;
      if (in_ready) begin
         for (int ch = 0; ch < 2; ch++) begin
            if (v[ch] && p[ch].pc_rdata != 32'd0) begin
               e.pcr  = p[ch].pc_rdata;
               e.pcw  = p[ch].pc_wdata;
               e.inst = p[ch].inst;
               e.ord  = exp_order;
               exp_order = exp_order + 64'd1;
               sb.push_back(e);
            end
         end
      end
      @(posedge clk);
      #1;
      in_valid = '0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_drain();
      int t;
      t = 0;
      while (sb.size() != 0 && t < 50) begin
         @(posedge clk);
         #1;
         t++;
      end
      if (t >= 50) chk_eq("drain_timeout", 64'(sb.size()), 64'd0);
   endtask

   always @(negedge clk) begin
      if (out_commit) begin
         n_commits++;
         if (sb.size() == 0) begin
            chk_eq("unexpected_commit", {32'd0, out_pkt.pc_rdata}, 64'd0);
         end else begin
            mon_e = sb.pop_front();
            chk_eq("commit_pc_rdata", 64'(out_pkt.pc_rdata), 64'(mon_e.pcr));
            chk_eq("commit_pc_wdata", 64'(out_pkt.pc_wdata), 64'(mon_e.pcw));
            chk_eq("commit_inst",     64'(out_pkt.inst),     64'(mon_e.inst));
            chk_eq("commit_order",    out_order,             mon_e.ord);
            chk_eq("commit_trap",     64'(out_trap),         64'(model_trap(mon_e.inst)));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      int occ;
      int base;
      int iter;
      rvfi_pkt_t z;
      z        = '0;
      rst      = 1'b0;
      in_valid = '0;
      in_pkt   = '0;
      #12;
      chk_eq("rst_commit",   64'(out_commit), 64'd0);
      chk_eq("rst_order",    out_order,       64'd0);
      chk_eq("rst_trap",     64'(out_trap),   64'd0);
      chk_eq("rst_halt",     64'(out_halt),   64'd0);
      chk_eq("rst_overflow", 64'(overflow),   64'd0);
      chk_eq("rst_ready",    64'(in_ready),   64'd1);
      chk_eq("rst_pkt",      64'(out_pkt.pc_rdata), 64'd0);
      // Strobe during reset must not be accepted.
      in_valid  = 2'b01;
      in_pkt[0] = mk(32'h990, 32'h994, 32'h13);
      @(posedge clk);
      #1;
      in_valid = '0;
      rst      = 1'b1;
      idle(3);
      chk_eq("no_push_in_reset", 64'(n_commits), 64'd0);

      // Single push: one-cycle latency
      drive(2'b01, mk(32'h60, 32'h64, 32'h13), z);
      chk_eq("lat_not_early", 64'(out_commit), 64'd0);
      @(posedge clk);
      #1;
      chk_eq("lat_commit", 64'(out_commit),       64'd1);
      chk_eq("lat_order",  out_order,             64'd0);
      chk_eq("lat_pc",     64'(out_pkt.pc_rdata), 64'h60);
      idle(1);
      chk_eq("lat_pulse", 64'(out_commit), 64'd0);

      // Dual push with a bubble
      base = n_commits;
      drive(2'b11, mk(32'h100, 32'h104, 32'h13), mk(32'h104, 32'h108, 32'h33));
      drive(2'b11, mk(32'h0,   32'h0,   32'h13), mk(32'h108, 32'h10C, 32'h13));
      wait_drain();
      chk_eq("bubble_commits", 64'(n_commits - base), 64'd3);

      // Trap decode
      drive(2'b11, mk(32'h300, 32'h304, 32'h0000A003), mk(32'h304, 32'h308, 32'h0000B003));
      drive(2'b11, mk(32'h308, 32'h30C, 32'h0000007F), mk(32'h30C, 32'h310, 32'h00002063));
      drive(2'b11, mk(32'h310, 32'h314, 32'h00003023), mk(32'h314, 32'h318, 32'h00000037));
      drive(2'b01, mk(32'h318, 32'h31C, 32'h00004103), z);
      wait_drain();

      // Halt detection
      drive(2'b01, mk(32'h200, 32'h200, 32'h6F), z);
      wait_drain();
      idle(2);
      chk_eq("halt_one", 64'(out_halt), 64'd0);
      drive(2'b01, mk(32'h204, 32'h208, 32'h13), z);
      drive(2'b01, mk(32'h200, 32'h200, 32'h6F), z);
      wait_drain();
      idle(2);
      chk_eq("halt_cleared", 64'(out_halt), 64'd0);
      drive(2'b01, mk(32'h200, 32'h200, 32'h6F), z);
      @(posedge clk);
      #1;
      chk_eq("halt_commit", 64'(out_commit), 64'd1);
      chk_eq("halt_not_yet", 64'(out_halt), 64'd0);
      @(posedge clk);
      #1;
      chk_eq("halt_set", 64'(out_halt), 64'd1);
      drive(2'b01, mk(32'h220, 32'h224, 32'h13), z);
      wait_drain();
      chk_eq("halt_sticky", 64'(out_halt), 64'd1);

      // Fill to not-ready, then violate
      idle(2);
      chk_eq("ovf_clear", 64'(overflow), 64'd0);
      base = n_commits;
      occ  = 0;
      iter = 0;
      while (iter < 12) begin
         chk_eq("fill_ready", 64'(in_ready), 64'(occ <= 6));
         if (!in_ready) break;
         drive(2'b11, mk(32'h1000 + 32'(iter) * 8, 32'h1004 + 32'(iter) * 8, 32'h13),
                      mk(32'h1004 + 32'(iter) * 8, 32'h1008 + 32'(iter) * 8, 32'h13));
         occ = occ + 2 - ((occ > 0) ? 1 : 0);
         iter++;
      end
      chk_eq("fill_occ", 64'(occ), 64'd7);
      drive(2'b01, mk(32'h2000, 32'h2004, 32'h13), z);
      chk_eq("ovf_set", 64'(overflow), 64'd1);
      wait_drain();
      idle(3);
      chk_eq("ovf_sticky", 64'(overflow), 64'd1);
      chk_eq("ovf_no_add", 64'(n_commits - base), 64'(2 * iter));

      // Reset with entries buffered
      for (int k = 0; k < 4; k++) begin
         drive(2'b11, mk(32'h500 + 32'(k) * 8, 32'h504 + 32'(k) * 8, 32'h13),
                      mk(32'h504 + 32'(k) * 8, 32'h508 + 32'(k) * 8, 32'h13));
      end
      rst = 1'b0;
      #1;
      chk_eq("mrst_commit",   64'(out_commit), 64'd0);
      chk_eq("mrst_order",    out_order,       64'd0);
      chk_eq("mrst_ready",    64'(in_ready),   64'd1);
      chk_eq("mrst_overflow", 64'(overflow),   64'd0);
      chk_eq("mrst_halt",     64'(out_halt),   64'd0);
      sb.delete();
      exp_order = '0;
      idle(2);
      rst  = 1'b1;
      base = n_commits;
      idle(4);
      chk_eq("mrst_quiet", 64'(n_commits - base), 64'd0);
      drive(2'b01, mk(32'h700, 32'h704, 32'h13), z);
      @(posedge clk);
      #1;
      chk_eq("mrst_first_commit", 64'(out_commit), 64'd1);
      chk_eq("mrst_first_order",  out_order,       64'd0);
      wait_drain();
      idle(2);
      chk_eq("sb_empty", 64'(sb.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
